// File: rtl/barret_arb_2957.sv
// Round-robin arbiter sharing one combinational Barrett reducer (mod 2957) behind a 2-stage
// valid/ready pipeline. Define BARRET_ARB_CHECK_EN to add a sticky self-check on every S2 load.
module barret_arb_2957 #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*23-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [11:0]          rsp_data,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 busy,
  output logic                 err
);

  localparam logic [22:0] MOD = 23'd2957;

  // Handshake rule: a transfer happens on a rising edge exactly when valid and ready are both
  // high in the cycle before it. Each stage advances when empty or when its consumer advances.

  // Barrett reduction with k = 12, mu = floor(2^24 / 2957) = 5673. The quotient estimate
  // undershoots by at most 2, so two conditional subtractions finish the job for x < 2^24.
  function automatic logic [11:0] barret_for_2957(input logic [22:0] x);
    logic [11:0] q1;
    logic [24:0] q2;
    logic [11:0] q3;
    logic [22:0] qm;
    logic [13:0] r;
    q1 = x[22:11];
    q2 = {13'd0, q1} * 25'd5673;
    q3 = 12'(q2 >> 13);
    qm = {11'd0, q3} * 23'd2957;
    r  = 14'(x - qm);
    if (r >= 14'd2957) r = r - 14'd2957;
    if (r >= 14'd2957) r = r - 14'd2957;
    return r[11:0];
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [22:0]      s1_op_q,    s1_op_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [11:0]      s2_data_q,  s2_data_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;
  logic [TAG_W-1:0] rr_ptr_q,   rr_ptr_d;

  logic             adv1;
  logic             adv2;
  logic             found;
  logic [TAG_W-1:0] grant;
  logic [TAG_W-1:0] grant_next;
  logic [TAG_W:0]   idx;
  logic [11:0]      red;

  assign adv2 = !s2_valid_q || rsp_ready;
  assign adv1 = !s1_valid_q || adv2;
  assign red  = barret_for_2957(s1_op_q);

  // Round-robin search starting at rr_ptr; idx is one bit wider so the wrap works for any NREQ.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (TAG_W+1)'(k);
      if (idx >= (TAG_W+1)'(NREQ)) idx = idx - (TAG_W+1)'(NREQ);
      if (!found && req_valid[idx[TAG_W-1:0]]) begin
        found = 1'b1;
        grant = idx[TAG_W-1:0];
      end
    end
  end

  always_comb begin
    grant_next = grant + TAG_W'(1);
    if (grant == TAG_W'(NREQ - 1)) grant_next = '0;
  end

  // rst_n gating keeps req_ready low while reset is held, even with requests pending.
  always_comb begin
    req_ready = '0;
    if (found && adv1 && rst_n) req_ready[grant] = 1'b1;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    rr_ptr_d   = rr_ptr_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = red;
      s2_tag_d   = s1_tag_q;
    end
    if (adv1) begin
      s1_valid_d = found;
      if (found) begin
        s1_op_d  = req_data[int'(grant)*23 +: 23];
        s1_tag_d = grant;
        rr_ptr_d = grant_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_data  = s2_data_q;
  assign rsp_tag   = s2_tag_q;
  assign busy      = s1_valid_q || s2_valid_q;

`ifdef BARRET_ARB_CHECK_EN
  logic        err_q, err_d;
  logic [11:0] ref_rem;

  always_comb begin
    ref_rem = 12'(s1_op_q % MOD);
    err_d   = err_q;
    if (adv2 && s1_valid_q && (red != ref_rem)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_barret_arb_2957.sv
// Bench for barret_arb_2957: directed scenarios plus a negedge scoreboard that models the
// arbiter as "first valid from the pointer" and the datapath as x % 2957 in acceptance order.
module tb_barret_arb_2957;
  localparam int NREQ  = 4;
  localparam int TAG_W = 2;
  localparam int M     = 2957;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*23-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [11:0]         rsp_data;
  logic [TAG_W-1:0]    rsp_tag;
  logic                busy;
  logic                err;

  barret_arb_2957 #(.NREQ(NREQ), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy),
    .err       (err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [13:0] exp_q[$];
  logic [11:0] got_q[$];
  logic [22:0] stim_q[$];
  int          model_ptr = 0;
  logic        hold_prev = 1'b0;
  logic [11:0] prev_data;
  logic [1:0]  prev_tag;
  logic        mon_found;
  int          mon_grant;
  logic        exp_any;
  logic [3:0]  exp_rdy;
  logic [13:0] exp_e;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (hold_prev) begin
        total_cnt++;
        if (rsp_valid !== 1'b1 || rsp_data !== prev_data || rsp_tag !== prev_tag)
          $display("FAIL rsp_hold: got v=%b d=%0d t=%0d expected v=1 d=%0d t=%0d",
                   rsp_valid, rsp_data, rsp_tag, prev_data, prev_tag);
        else pass_cnt++;
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
      prev_tag  = rsp_tag;

      mon_found = 1'b0;
      mon_grant = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!mon_found && req_valid[(model_ptr + k) % NREQ]) begin
          mon_found = 1'b1;
          mon_grant = (model_ptr + k) % NREQ;
        end
      end
      // At most two operands can be in flight; a third is taken only if one leaves now.
      exp_any = mon_found && (exp_q.size() < 2 || rsp_ready);
      exp_rdy = exp_any ? (4'b0001 << mon_grant) : 4'b0000;
      total_cnt++;
      if (req_ready !== exp_rdy)
        $display("FAIL arb_grant: got req_ready=%b expected %b", req_ready, exp_rdy);
      else pass_cnt++;

      if (rsp_valid && rsp_ready) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL rsp_unexpected: got d=%0d t=%0d expected no response", rsp_data, rsp_tag);
        end else begin
          exp_e = exp_q.pop_front();
          if ({rsp_tag, rsp_data} !== exp_e)
            $display("FAIL rsp_data: got t=%0d d=%0d expected t=%0d d=%0d",
                     rsp_tag, rsp_data, exp_e[13:12], exp_e[11:0]);
          else pass_cnt++;
        end
        got_q.push_back(rsp_data);
      end

      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({2'(i), 12'(int'(req_data[i*23 +: 23]) % M)});
          model_ptr = (i + 1) % NREQ;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_model();
    exp_q.delete();
    model_ptr = 0;
    hold_prev = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_model();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic stream(input int r);
    int wait_cnt;
    while (stim_q.size() > 0) begin
      req_data[r*23 +: 23] = stim_q.pop_front();
      req_valid[r] = 1'b1;
      wait_cnt = 0;
      do begin
        @(negedge clk);
        wait_cnt++;
      end while (!req_ready[r] && wait_cnt < 1000);
      if (!req_ready[r]) begin
        total_cnt++;
        $display("FAIL stream_timeout: got no req_ready[%0d] expected it within 1000 cycles", r);
        stim_q.delete();
      end
      @(posedge clk); #1;
    end
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int wait_cnt;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_cnt  = 0;
    do begin
      @(negedge clk);
      wait_cnt++;
    end while (exp_q.size() != 0 && wait_cnt < 100);
    @(posedge clk); #1;
    total_cnt++;
    if (exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL drain: got pending=%0d busy=%b expected pending=0 busy=0", exp_q.size(), busy);
    else pass_cnt++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = {$urandom, $urandom, $urandom};
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({rsp_valid, busy, err, req_ready, rsp_tag, rsp_data} !== 20'd0)
      $display("FAIL reset_state: got v=%b busy=%b err=%b rdy=%b t=%0d d=%0d expected all 0",
               rsp_valid, busy, err, req_ready, rsp_tag, rsp_data);
    else pass_cnt++;
    req_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic single_op(input logic [22:0] op);
    logic [11:0] expv;
    expv = 12'(int'(op) % M);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_data[22:0] = op;
    req_valid = 4'b0001;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b expected 0001", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    req_valid = '0;
    total_cnt++;
    if (rsp_valid !== 1'b0) $display("FAIL single_lat_early: got rsp_valid=%b expected 0", rsp_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_data !== expv || rsp_tag !== 2'd0)
      $display("FAIL single_rsp: got v=%b d=%0d t=%0d expected v=1 d=%0d t=0",
               rsp_valid, rsp_data, rsp_tag, expv);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    single_op(23'd5914);
    single_op(23'd2956);
    drain();
  endtask

  task automatic test_all_four();
    apply_reset();
    got_q.delete();
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[i*23 +: 23] = 23'(3000 + i);
    req_valid = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total_cnt++;
      if (req_ready !== (4'b0001 << (k % 4)))
        $display("FAIL rr_order: got %b expected %b at accept %0d", req_ready, 4'b0001 << (k % 4), k);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    drain();
    total_cnt++;
    if (got_q.size() != 12) $display("FAIL rr_count: got %0d expected 12", got_q.size());
    else pass_cnt++;
    for (int k = 0; k < got_q.size() && k < 12; k++) begin
      total_cnt++;
      if (got_q[k] !== 12'((3000 + k % 4) % M))
        $display("FAIL rr_value: got %0d expected %0d", got_q[k], (3000 + k % 4) % M);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [11:0] snap_d;
    logic [1:0]  snap_t;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_data[1*23 +: 23] = 23'($urandom_range(0, 8388607));
    req_data[3*23 +: 23] = 23'($urandom_range(0, 8388607));
    req_valid = 4'b1010;
    repeat (2) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        snap_d = rsp_data;
        snap_t = rsp_tag;
      end
      total_cnt++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== snap_d || rsp_tag !== snap_t)
        $display("FAIL stall: got rdy=%b v=%b d=%0d t=%0d expected rdy=0000 v=1 d=%0d t=%0d",
                 req_ready, rsp_valid, rsp_data, rsp_tag, snap_d, snap_t);
      else pass_cnt++;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_boundary();
    logic [22:0] ops[4];
    ops = '{23'd0, 23'd2956, 23'd2957, 23'd8388607};
    got_q.delete();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) stim_q.push_back(ops[k]);
    stream(3);
    drain();
    total_cnt++;
    if (got_q.size() != 4) $display("FAIL boundary_count: got %0d expected 4", got_q.size());
    else pass_cnt++;
    for (int k = 0; k < got_q.size() && k < 4; k++) begin
      total_cnt++;
      if (got_q[k] !== 12'(int'(ops[k]) % M))
        $display("FAIL boundary_value: got %0d expected %0d", got_q[k], int'(ops[k]) % M);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) req_data[i*23 +: 23] = 23'($urandom_range(0, 8388607));
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    clear_model();
    #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000)
      $display("FAIL async_reset: got v=%b busy=%b rdy=%b expected 0 0 0000", rsp_valid, busy, req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
    else pass_cnt++;
    repeat (4) begin
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_sweep();
    bit done;
    done = 1'b0;
    got_q.delete();
    for (int v = 0; v < M; v++) stim_q.push_back(23'(v));
    @(posedge clk); #1;
    fork
      begin
        stream(2);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          if (!done) rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    total_cnt++;
    if (got_q.size() != M) $display("FAIL sweep_count: got %0d expected %0d", got_q.size(), M);
    else pass_cnt++;
    for (int k = 0; k < got_q.size() && k < M; k++) begin
      total_cnt++;
      if (got_q[k] !== 12'(k)) $display("FAIL sweep_value: got %0d expected %0d", got_q[k], k);
      else pass_cnt++;
    end
    total_cnt++;
    if (err !== 1'b0) $display("FAIL sweep_err: got err=%b expected 0", err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_stall();
    test_boundary();
    test_async_reset();
    test_sweep();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
